// File: rtl/game_pkg.sv
// Shared definitions for the game logic blocks.
// Scan FSM encodings and position width defaults.
package game_pkg;

   localparam int GAME_POS_WIDTH = 8;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SCAN   = 2'd1;
   localparam logic [1:0] FINISH = 2'd2;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pos_match.sv
// One probe against the segment currently under scan.
// An absent probe or segment never matches.
module pos_match
   import game_pkg::*;
#(
   parameter int POS_WIDTH = GAME_POS_WIDTH
) (
   input  logic [POS_WIDTH-1:0] probe_pos,
   input  logic                 probe_valid,
   input  logic [POS_WIDTH-1:0] seg_pos,
   input  logic                 seg_active,
   output logic                 match
);

   assign match = probe_valid && seg_active && (probe_pos == seg_pos);

endmodule

// File: rtl/collision_scan_unit.sv
// Frame-based collision scan: one segment per clock, all probes in parallel.
// Results update once per scan and are held until the next done pulse.
module collision_scan_unit
   import game_pkg::*;
#(
   parameter int NUM_SEGMENTS = 7,
   parameter int NUM_PROBES   = 2,
   parameter int POS_WIDTH    = GAME_POS_WIDTH,
   localparam int IDX_W       = idx_width(NUM_SEGMENTS)
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             start,
   input  logic [NUM_PROBES*POS_WIDTH-1:0]   probe_pos,
   input  logic [NUM_PROBES-1:0]             probe_valid,
   input  logic [NUM_SEGMENTS*POS_WIDTH-1:0] seg_pos,
   input  logic [NUM_SEGMENTS-1:0]           seg_active,
   output logic                             busy,
   output logic                             done,
   output logic [NUM_PROBES-1:0]             hit_flags,
   output logic [NUM_PROBES*IDX_W-1:0]       hit_index,
   output logic [NUM_SEGMENTS-1:0]           seg_hit_mask
);

   logic [1:0]                        state;
   logic [IDX_W-1:0]                  seg_idx;
   logic [NUM_PROBES*POS_WIDTH-1:0]   probe_q;
   logic [NUM_PROBES-1:0]             valid_q;
   logic [POS_WIDTH-1:0]              seg_q [NUM_SEGMENTS];
   logic [NUM_SEGMENTS-1:0]           active_q;

   logic [NUM_PROBES-1:0]             acc_hit;
   logic [NUM_PROBES-1:0]             acc_hit_nx;
   logic [NUM_PROBES*IDX_W-1:0]       acc_idx;
   logic [NUM_PROBES*IDX_W-1:0]       acc_idx_nx;
   logic [NUM_SEGMENTS-1:0]           acc_mask;
   logic [NUM_SEGMENTS-1:0]           acc_mask_nx;

   logic [NUM_PROBES-1:0]             match;
   logic [POS_WIDTH-1:0]              cur_pos;
   logic                              cur_active;
   logic                              last;

   assign cur_pos    = seg_q[seg_idx];
   assign cur_active = active_q[seg_idx];
   assign last       = (seg_idx == IDX_W'(NUM_SEGMENTS - 1));

   for (genvar g = 0; g < NUM_PROBES; g++) begin : g_probe
      pos_match #(
         .POS_WIDTH (POS_WIDTH)
      ) u_match (
         .probe_pos   (probe_q[g*POS_WIDTH +: POS_WIDTH]),
         .probe_valid (valid_q[g]),
         .seg_pos     (cur_pos),
         .seg_active  (cur_active),
         .match       (match[g])
      );
   end

   // First hit wins the index; later hits only keep the flag set.
   always_comb begin
      acc_hit_nx  = acc_hit | match;
      acc_idx_nx  = acc_idx;
      acc_mask_nx = acc_mask;
      for (int k = 0; k < NUM_PROBES; k++) begin
         if (match[k] && !acc_hit[k])
            acc_idx_nx[k*IDX_W +: IDX_W] = seg_idx;
      end
      if (|match)
         acc_mask_nx[seg_idx] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state        <= IDLE;
         seg_idx      <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         hit_flags    <= '0;
         hit_index    <= '0;
         seg_hit_mask <= '0;
         acc_hit      <= '0;
         acc_idx      <= '0;
         acc_mask     <= '0;
         probe_q      <= '0;
         valid_q      <= '0;
         active_q     <= '0;
         for (int i = 0; i < NUM_SEGMENTS; i++)
            seg_q[i] <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  probe_q  <= probe_pos;
                  valid_q  <= probe_valid;
                  active_q <= seg_active;
                  for (int i = 0; i < NUM_SEGMENTS; i++)
                     seg_q[i] <= seg_pos[i*POS_WIDTH +: POS_WIDTH];
                  acc_hit  <= '0;
                  acc_idx  <= '0;
                  acc_mask <= '0;
                  seg_idx  <= '0;
                  busy     <= 1'b1;
                  state    <= SCAN;
               end
            end
            SCAN: begin
               acc_hit  <= acc_hit_nx;
               acc_idx  <= acc_idx_nx;
               acc_mask <= acc_mask_nx;
               seg_idx  <= seg_idx + 1'b1;
               // Publish on the last slot so done lands in the FINISH cycle.
               if (last) begin
                  hit_flags    <= acc_hit_nx;
                  hit_index    <= acc_idx_nx;
                  seg_hit_mask <= acc_mask_nx;
                  done         <= 1'b1;
                  busy         <= 1'b0;
                  state        <= FINISH;
               end
            end
            FINISH: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_collision_scan_unit.sv
// Self-checking bench for collision_scan_unit.
// Vector table plus scoreboard queue and a few multi-cycle sequences.
module tb_collision_scan_unit;

   localparam int NS = 7;
   localparam int NP = 2;
   localparam int PW = 8;
   localparam int IW = 3;

   typedef struct {
      string           name;
      logic [NP*PW-1:0] pp;
      logic [NP-1:0]    pv;
      logic [NS*PW-1:0] sp;
      logic [NS-1:0]    sa;
      logic [NP-1:0]    ef;
      logic [NP*IW-1:0] ei;
      logic [NS-1:0]    em;
   } vec_t;

   typedef struct {
      string           name;
      logic [NP-1:0]    f;
      logic [NP*IW-1:0] i;
      logic [NS-1:0]    m;
   } exp_t;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             start = 1'b0;
   logic [NP*PW-1:0] probe_pos = '0;
   logic [NP-1:0]    probe_valid = '0;
   logic [NS*PW-1:0] seg_pos = '0;
   logic [NS-1:0]    seg_active = '0;
   logic             busy;
   logic             done;
   logic [NP-1:0]    hit_flags;
   logic [NP*IW-1:0] hit_index;
   logic [NS-1:0]    seg_hit_mask;

   int n_cmp = 0;
   int n_bad = 0;
   exp_t sb[$];
   vec_t vecs[$];

   always #5 clk = ~clk;

   collision_scan_unit dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .probe_pos    (probe_pos),
      .probe_valid  (probe_valid),
      .seg_pos      (seg_pos),
      .seg_active   (seg_active),
      .busy         (busy),
      .done         (done),
      .hit_flags    (hit_flags),
      .hit_index    (hit_index),
      .seg_hit_mask (seg_hit_mask)
   );

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   function automatic logic [NS*PW-1:0] base_segs();
      logic [NS*PW-1:0] s;
      for (int i = 0; i < NS; i++)
         s[i*PW +: PW] = 8'hA0 + 8'(i);
      return s;
   endfunction

   function automatic logic [NS*PW-1:0] set_seg(input logic [NS*PW-1:0] s,
                                                input int i, input logic [7:0] v);
      logic [NS*PW-1:0] r;
      r = s;
      r[i*PW +: PW] = v;
      return r;
   endfunction

   function automatic logic [NP*PW-1:0] probes(input logic [7:0] p0,
                                               input logic [7:0] p1);
      return {p1, p0};
   endfunction

   function automatic logic [NP*IW-1:0] idx(input int i0, input int i1);
      logic [NP*IW-1:0] r;
      r = '0;
      r[0 +: IW]  = IW'(i0);
      r[IW +: IW] = IW'(i1);
      return r;
   endfunction

   task automatic apply(input vec_t v);
      probe_pos   = v.pp;
      probe_valid = v.pv;
      seg_pos     = v.sp;
      seg_active  = v.sa;
   endtask

   task automatic check_outputs(input string name, input exp_t e);
      check({name, ".flags"}, 64'(hit_flags), 64'(e.f));
      check({name, ".index"}, 64'(hit_index), 64'(e.i));
      check({name, ".mask"},  64'(seg_hit_mask), 64'(e.m));
   endtask

   // Start pulse before posedge 0; done must appear in cycle 8.
   task automatic run_scan(input vec_t v);
      exp_t e;
      bit   got;
      int   busy_bad;
      e.name = v.name;
      e.f    = v.ef;
      e.i    = v.ei;
      e.m    = v.em;
      apply(v);
      start = 1'b1;
      sb.push_back(e);
      got = 0;
      busy_bad = 0;
      for (int k = 1; k <= 20 && !got; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (k <= NS && busy !== 1'b1)
            busy_bad++;
         if (done === 1'b1) begin
            got = 1;
            check({v.name, ".latency"}, 64'(k), 64'(NS + 1));
            check({v.name, ".busy_off"}, 64'(busy), 64'(0));
            if (sb.size() == 0) begin
               check({v.name, ".sb_empty"}, 64'(1), 64'(0));
            end else begin
               e = sb.pop_front();
               check_outputs(e.name, e);
            end
         end
      end
      check({v.name, ".busy_during"}, 64'(busy_bad), 64'(0));
      if (!got)
         check({v.name, ".timeout"}, 64'(0), 64'(1));
      @(negedge clk);
      check({v.name, ".done_pulse"}, 64'(done), 64'(0));
      check_outputs({v.name, ".held"}, '{v.name, v.ef, v.ei, v.em});
   endtask

   vec_t v;
   exp_t zero_e;
   int   dcount;

   initial begin
      zero_e = '{"zero", '0, '0, '0};

      // Reset then idle
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      begin
         int bad;
         bad = 0;
         for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (busy !== 1'b0 || done !== 1'b0 || hit_flags !== '0 ||
                hit_index !== '0 || seg_hit_mask !== '0)
               bad++;
         end
         check("reset_idle", 64'(bad), 64'(0));
      end

      // Vector table
      vecs.push_back('{"player_hit", probes(8'h34, 8'h00), 2'b01,
                       set_seg(base_segs(), 3, 8'h34), 7'h7F,
                       2'b01, idx(3, 0), 7'b0001000});
      vecs.push_back('{"inactive_seg", probes(8'h34, 8'h00), 2'b01,
                       set_seg(base_segs(), 3, 8'h34), 7'h77,
                       2'b00, idx(0, 0), 7'b0000000});
      v.sp = set_seg(base_segs(), 1, 8'h11);
      v.sp = set_seg(v.sp, 5, 8'h11);
      v.sp = set_seg(v.sp, 2, 8'h22);
      vecs.push_back('{"two_probes", probes(8'h11, 8'h22), 2'b11,
                       v.sp, 7'h7F, 2'b11, idx(1, 2), 7'b0100110});
      vecs.push_back('{"invalid_sword", probes(8'h55, 8'hA4), 2'b01,
                       base_segs(), 7'h7F, 2'b00, idx(0, 0), 7'b0000000});
      vecs.push_back('{"valid_sword", probes(8'h55, 8'hA4), 2'b10,
                       base_segs(), 7'h7F, 2'b10, idx(0, 4), 7'b0010000});
      v.sp = set_seg(base_segs(), 0, 8'h77);
      v.sp = set_seg(v.sp, 4, 8'h77);
      v.sp = set_seg(v.sp, 6, 8'h66);
      vecs.push_back('{"edge_segs", probes(8'h77, 8'h66), 2'b11,
                       v.sp, 7'h7F, 2'b11, idx(0, 6), 7'b1010001});
      vecs.push_back('{"shared_seg", probes(8'h42, 8'h42), 2'b11,
                       set_seg(base_segs(), 5, 8'h42), 7'h7F,
                       2'b11, idx(5, 5), 7'b0100000});

      for (int t = 0; t < vecs.size(); t++) begin
         @(negedge clk);
         run_scan(vecs[t]);
      end

      // Snapshot and start-ignore
      @(negedge clk);
      apply(vecs[0]);
      start = 1'b1;
      dcount = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (k == 3) begin
            seg_pos = set_seg(seg_pos, 3, 8'h00);
            start = 1'b1;
         end
         if (done === 1'b1) begin
            dcount++;
            check("snap.latency", 64'(k), 64'(NS + 1));
            check_outputs("snap", '{"snap", 2'b01, idx(3, 0), 7'b0001000});
            start = 1'b1;
         end
      end
      check("snap.done_count", 64'(dcount), 64'(1));
      check("snap.finish_start_ignored", 64'(busy), 64'(0));

      // Start one cycle after FINISH is accepted
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("restart.busy", 64'(busy), 64'(1));
      for (int k = 0; k < 20 && done !== 1'b1; k++)
         @(negedge clk);
      @(negedge clk);

      // Reset mid-scan
      apply(vecs[0]);
      start = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         start = 1'b0;
      end
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      dcount = 0;
      for (int k = 0; k < 12; k++) begin
         if (done === 1'b1)
            dcount++;
         @(negedge clk);
      end
      check("rst_mid.done_count", 64'(dcount), 64'(0));
      check("rst_mid.busy", 64'(busy), 64'(0));
      check_outputs("rst_mid", zero_e);

      run_scan(vecs[2]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
